// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver with majority-vote sampling and a
// valid/ready receive FIFO.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          uart_rx_i,
    output logic [7:0]                    data_o,
    output logic                          data_vld_o,
    input  logic                          data_rdy_i,
    output logic                          frame_err_o,
    output logic                          overrun_err_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned DIV    = CLK_FREQ / (BAUD * 16);
    localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [3:0]         s_q, s_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [1:0]         smp_q, smp_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;

    logic               rx_meta_q, rx_sync_q, rx_prev_q;
    logic               fall_c, tick_c, maj_c, at9_c, at15_c, push_c;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pop_c, full_c, wr_c;

    // Line synchronizer plus edge-detect stage; idle-high reset avoids a false start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall_c = rx_prev_q & ~rx_sync_q;
    assign tick_c = (tick_q == TICK_W'(DIV - 1));
    assign at9_c  = tick_c && (s_q == 4'd9);
    assign at15_c = tick_c && (s_q == 4'd15);
    assign maj_c  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tick_q  <= '0;
            s_q     <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            smp_q   <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            smp_q   <= smp_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Receive FSM: oversample timing, bit decisions and frame outcome.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_c ? '0 : tick_q + TICK_W'(1);
        s_d     = tick_c ? s_q + 4'd1 : s_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        smp_d   = smp_q;
        ferr_d  = 1'b0;
        push_c  = 1'b0;

        if (tick_c && (s_q == 4'd7)) smp_d[0] = rx_sync_q;
        if (tick_c && (s_q == 4'd8)) smp_d[1] = rx_sync_q;

        unique case (state_q)
            IDLE: begin
                if (fall_c) begin
                    tick_d  = '0;
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (at9_c && maj_c) begin
                    state_d = IDLE;
                end else if (at15_c) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at9_c) shift_d = {maj_c, shift_q[7:1]};
                if (at15_c) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (at9_c) begin
                    if (maj_c) begin
                        push_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop_c  = data_vld_o & data_rdy_i;
    assign full_c = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_c   = push_c & (~full_c | pop_c);

    // Occupancy and overrun decision.
    always_comb begin
        count_d = count_q;
        ovr_d   = push_c & full_c & ~pop_c;
        if (wr_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (pop_c && !wr_c) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_c) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign data_o        = mem_q[rd_ptr_q];
    assign data_vld_o    = (count_q != '0);
    assign fifo_level_o  = count_q;
    assign frame_err_o   = ferr_q;
    assign overrun_err_o = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo; expected bytes come from a
// queue model of what a UART receiver with an 8-entry FIFO should deliver.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ = 1600000;
    localparam int unsigned BAUD     = 10000;
    localparam int unsigned DEPTH    = 8;
    localparam int          BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rdy = 1'b0;
    logic [7:0] data_o;
    logic       data_vld_o;
    logic       frame_err_o;
    logic       overrun_err_o;
    logic [3:0] fifo_level_o;

    uart_rx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .uart_rx_i    (rx),
        .data_o       (data_o),
        .data_vld_o   (data_vld_o),
        .data_rdy_i   (rdy),
        .frame_err_o  (frame_err_o),
        .overrun_err_o(overrun_err_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every accepted byte and every error pulse.
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         vld_cnt = 0, fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (data_vld_o) vld_cnt++;
        if (data_vld_o && rdy) begin
            got_q.push_back(data_o);
            got_cyc.push_back(cyc);
        end
        if (frame_err_o) fe_cnt++;
        if (overrun_err_o) ov_cnt++;
        if (frame_err_o && overrun_err_o) both_cnt++;
    end

    int         tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    int         got_rd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(BIT_CLKS);
        end
        rx = stop_v;
        step(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b1);
    endtask

    // Compare bytes accepted since the last call against the model queue.
    task automatic check_rx(input string tag);
        check({tag, "_count"}, 32'(got_q.size() - got_rd), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (got_rd + k < got_q.size())
                check({tag, "_data"}, 32'(got_q[got_rd + k]), 32'(exp_q[k]));
        end
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        int         t0, lat, base_v, base_fe, base_ov, lvl, exp_ov;
        logic [7:0] b;
        logic [7:0] pat;

        // Reset state
        rst_n = 1'b0;
        step(5);
        check("rst_data",  32'(data_o), 32'd0);
        check("rst_vld",   32'(data_vld_o), 32'd0);
        check("rst_ferr",  32'(frame_err_o), 32'd0);
        check("rst_ovr",   32'(overrun_err_o), 32'd0);
        check("rst_level", 32'(fifo_level_o), 32'd0);
        rst_n = 1'b1;
        step(20);

        // Single frame 0xA5 with consumer ready
        rdy = 1'b1;
        base_v = vld_cnt; base_fe = fe_cnt; base_ov = ov_cnt;
        t0 = cyc;
        send_frame(8'hA5);
        step(300);
        lat = (got_cyc.size() > got_rd) ? got_cyc[got_rd] - t0 : 0;
        exp_q.push_back(8'hA5);
        check_rx("a5");
        check("a5_vld_cycles", 32'(vld_cnt - base_v), 32'd1);
        check("a5_latency_ok", 32'(lat >= 1400 && lat <= 1650), 32'd1);
        check("a5_ferr", 32'(fe_cnt - base_fe), 32'd0);
        check("a5_ovr",  32'(ov_cnt - base_ov), 32'd0);

        // Start glitch shorter than half a bit is rejected
        rx = 1'b0;
        step(40);
        rx = 1'b1;
        step(300);
        check("glitch_no_push", 32'(got_q.size() - got_rd), 32'd0);
        check("glitch_level", 32'(fifo_level_o), 32'd0);
        check("glitch_ferr", 32'(fe_cnt - base_fe), 32'd0);
        send_frame(8'h5A);
        step(300);
        exp_q.push_back(8'h5A);
        check_rx("after_glitch");

        // Framing error followed by a held-low break
        base_fe = fe_cnt;
        send_bits(8'h3C, 1'b0);
        step(500);
        rx = 1'b1;
        step(300);
        rdy = 1'b0;
        send_frame(8'h81);
        step(300);
        check("ferr_once", 32'(fe_cnt - base_fe), 32'd1);
        check("ferr_level", 32'(fifo_level_o), 32'd1);
        check("ferr_vld", 32'(data_vld_o), 32'd1);
        check("ferr_head", 32'(data_o), 32'h81);
        rdy = 1'b1;
        step(5);
        exp_q.push_back(8'h81);
        check_rx("ferr");

        // Overrun: nine frames into an eight-entry FIFO with no consumer
        rdy = 1'b0;
        base_ov = ov_cnt;
        lvl = 0;
        exp_ov = 0;
        for (int v = 1; v <= 9; v++) begin
            send_frame(8'(v));
            if (lvl < int'(DEPTH)) begin
                exp_q.push_back(8'(v));
                lvl++;
            end else begin
                exp_ov++;
            end
        end
        step(300);
        check("ovr_level", 32'(fifo_level_o), 32'(lvl));
        check("ovr_pulses", 32'(ov_cnt - base_ov), 32'(exp_ov));
        rdy = 1'b1;
        step(20);
        check_rx("ovr_drain");
        check("ovr_vld_after", 32'(data_vld_o), 32'd0);
        check("ovr_level_after", 32'(fifo_level_o), 32'd0);

        // Random bytes with random idle gaps (zero gap = back-to-back)
        base_fe = fe_cnt; base_ov = ov_cnt;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            send_frame(b);
            exp_q.push_back(b);
            step(int'($urandom_range(0, 150)));
        end
        step(300);
        check_rx("rand");
        check("rand_ferr", 32'(fe_cnt - base_fe), 32'd0);
        check("rand_ovr",  32'(ov_cnt - base_ov), 32'd0);

        // Asynchronous reset during data bit 3 of 0x77, with a byte parked in the FIFO
        rdy = 1'b0;
        b = 8'($urandom);
        send_frame(b);
        step(300);
        check("prerst_level", 32'(fifo_level_o), 32'd1);
        pat = 8'h77;
        rx = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = pat[i];
            step(BIT_CLKS);
        end
        rx = pat[3];
        step(BIT_CLKS / 2);
        base_fe = fe_cnt; base_ov = ov_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("arst_data",  32'(data_o), 32'd0);
        check("arst_vld",   32'(data_vld_o), 32'd0);
        check("arst_level", 32'(fifo_level_o), 32'd0);
        check("arst_ferr",  32'(frame_err_o), 32'd0);
        check("arst_ovr",   32'(overrun_err_o), 32'd0);
        rx = 1'b1;
        step(10);
        rst_n = 1'b1;
        step(50);
        rdy = 1'b1;
        send_frame(8'h55);
        step(300);
        exp_q.push_back(8'h55);
        check_rx("after_rst");
        check("rst_no_ferr", 32'(fe_cnt - base_fe), 32'd0);
        check("rst_no_ovr",  32'(ov_cnt - base_ov), 32'd0);

        // Back-to-back 0x00 then 0xFF
        base_fe = fe_cnt; base_ov = ov_cnt;
        send_frame(8'h00);
        send_frame(8'hFF);
        step(300);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        check_rx("b2b");
        check("b2b_ferr", 32'(fe_cnt - base_fe), 32'd0);
        check("b2b_ovr",  32'(ov_cnt - base_ov), 32'd0);

        check("err_exclusive", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
